// File: rtl/proc_pkg.sv
// Shared definitions for the teaching processor: fetch FSM states and default widths.
package proc_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2
  } state_t;

endpackage

// File: rtl/mux_8_bit.sv
// Generic 8-bit 2:1 select: y_c = ctrl ? a : b.
module mux_8_bit (
  input  logic       ctrl,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y_c
);

  assign y_c = ctrl ? a : b;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer: req/ack fetch from imem,
// valid/ready hand-off downstream, branch redirect and sticky fetch timeout.
module pc_fetch_unit #(
  parameter int unsigned             ADDR_W   = proc_pkg::ADDR_W,
  parameter int unsigned             DATA_W   = proc_pkg::DATA_W,
  parameter logic [ADDR_W-1:0]       RESET_PC = ADDR_W'(proc_pkg::RESET_PC),
  parameter int unsigned             TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc_out,
  output logic              fetch_err
);

  import proc_pkg::*;

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_d;
  logic [DATA_W-1:0] instr_d;
  logic [ADDR_W-1:0] ipc_d;
  logic              req_d;
  logic              valid_d;

  logic [7:0]        mux_a, mux_b, mux_y;
  logic [ADDR_W-1:0] pc_next_c;

  // Next-PC select: branch target wins over sequential increment
  assign mux_a     = 8'(branch_target);
  assign mux_b     = 8'(pc_q + ADDR_W'(1));
  assign pc_next_c = ADDR_W'(mux_y);

  mux_8_bit u_next_pc_mux (
    .ctrl (branch_taken),
    .a    (mux_a),
    .b    (mux_b),
    .y_c  (mux_y)
  );

  assign imem_addr = pc_q;
  assign pc_out    = pc_q;

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    err_d   = fetch_err;
    instr_d = instr_out;
    ipc_d   = instr_pc;

    unique case (state_q)
      S_IDLE: begin
        if (!stall && !fetch_err) state_d = S_REQ;
      end
      S_REQ: begin
        if (branch_taken) begin
          // redirect drops the outstanding request, including a same-cycle ack
          cnt_d = '0;
        end else if (imem_ack) begin
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          cnt_d   = '0;
          state_d = S_VALID;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_VALID: begin
        if (branch_taken || (instr_ready && !stall)) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    if (branch_taken || (state_q == S_REQ && imem_ack)) pc_d = pc_next_c;

    req_d   = (state_d == S_REQ);
    valid_d = (state_d == S_VALID);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      cnt_q       <= '0;
      fetch_err   <= 1'b0;
      instr_out   <= '0;
      instr_pc    <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      fetch_err   <= err_d;
      instr_out   <= instr_d;
      instr_pc    <= ipc_d;
      imem_req    <= req_d;
      instr_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a latency-1 memory model serves fetches,
// directed stimulus queues expected instructions, a monitor checks each hand-off.
module tb_pc_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_rdata;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_out;
  logic [7:0] instr_pc;
  logic [7:0] pc_out;
  logic       fetch_err;

  typedef struct packed {
    logic [7:0] instr;
    logic [7:0] pc;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] mem [256];
  logic       mem_en;
  int         mem_lat;
  int         wait_cnt = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(
    .ADDR_W   (8),
    .DATA_W   (8),
    .RESET_PC (8'h00),
    .TIMEOUT  (15)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_out     (instr_out),
    .instr_pc      (instr_pc),
    .pc_out        (pc_out),
    .fetch_err     (fetch_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [7:0] instr, input logic [7:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    sb_q.push_back(e);
  endtask

  // one cycle: land 1 time unit after the falling edge
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Memory model: acks after mem_lat waiting cycles of a held request
  always @(negedge clk) begin
    if (imem_req && mem_en) begin
      if (wait_cnt >= mem_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[imem_addr];
        wait_cnt   = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 8'h00;
        wait_cnt   = wait_cnt + 1;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 8'h00;
      wait_cnt   = 0;
    end
  end

  // Monitor: every completed hand-off must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst && instr_valid && instr_ready && !stall && !branch_taken) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra: got instr %0h pc %0h expected nothing", instr_out, instr_pc);
        end else begin
          e = sb_q.pop_front();
          chk("sb_instr", 32'(instr_out), 32'(e.instr));
          chk("sb_pc", 32'(instr_pc), 32'(e.pc));
        end
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
    mem[8'h03] = 8'hA5;
    mem[8'h05] = 8'h77;
    imem_ack = 1'b0;
    imem_rdata = 8'h00;
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    instr_ready = 1'b1; mem_en = 1'b1; mem_lat = 1;
    step(); step();

    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_out", 32'(instr_out), 32'h0);
    chk("rst_ipc", 32'(instr_pc), 32'h0);
    chk("rst_pc", 32'(pc_out), 32'h00);
    chk("rst_err", 32'(fetch_err), 32'h0);

    // free run 00..02
    push_exp(8'h3C, 8'h00);
    push_exp(8'h3D, 8'h01);
    push_exp(8'h3E, 8'h02);
    rst = 1'b0;
    step();
    chk("first_req_addr", 32'(imem_req ? imem_addr : 8'hEE), 32'h00);
    n = 0;
    while (!(instr_valid && instr_pc == 8'h02) && n < 40) begin step(); n++; end
    chk("wait_v02", 32'(n < 40), 32'h1);
    chk("pc_after_02", 32'(pc_out), 32'h03);
    step();
    instr_ready = 1'b0;

    // backpressure on A5 at 03
    n = 0;
    while (!instr_valid && n < 10) begin step(); n++; end
    chk("bp_pc", 32'(instr_pc), 32'h03);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(instr_valid), 32'h1);
      chk("bp_out", 32'(instr_out), 32'hA5);
      chk("bp_req", 32'(imem_req), 32'h0);
      step();
    end
    push_exp(8'hA5, 8'h03);
    push_exp(8'h38, 8'h04);
    instr_ready = 1'b1;
    step();
    chk("bp_next_addr", 32'(imem_req ? imem_addr : 8'hEE), 32'h04);

    // branch colliding with ack of 77 at 05
    n = 0;
    while (!(imem_ack && imem_addr == 8'h05) && n < 20) begin step(); n++; end
    chk("wait_ack05", 32'(n < 20), 32'h1);
    branch_taken = 1'b1;
    branch_target = 8'h40;
    push_exp(8'h7C, 8'h40);
    step();
    branch_taken = 1'b0;
    chk("col_req", 32'(imem_req), 32'h1);
    chk("col_addr", 32'(imem_addr), 32'h40);
    chk("col_pc", 32'(pc_out), 32'h40);
    chk("col_valid", 32'(instr_valid), 32'h0);

    // branch while 41 is valid and ready
    n = 0;
    while (!(instr_valid && instr_pc == 8'h41) && n < 20) begin step(); n++; end
    chk("wait_v41", 32'(n < 20), 32'h1);
    branch_taken = 1'b1;
    branch_target = 8'h10;
    push_exp(8'h2C, 8'h10);
    step();
    branch_taken = 1'b0;
    chk("flush_valid", 32'(instr_valid), 32'h0);
    chk("flush_req", 32'(imem_req), 32'h1);
    chk("flush_addr", 32'(imem_addr), 32'h10);

    // redirect an unacked request to FE, then wrap FE,FF,00
    n = 0;
    while (!(instr_valid && instr_pc == 8'h10) && n < 20) begin step(); n++; end
    chk("wait_v10", 32'(n < 20), 32'h1);
    step();
    chk("req11_addr", 32'(imem_req ? imem_addr : 8'hEE), 32'h11);
    branch_taken = 1'b1;
    branch_target = 8'hFE;
    push_exp(8'hC2, 8'hFE);
    push_exp(8'hC3, 8'hFF);
    push_exp(8'h3C, 8'h00);
    step();
    branch_taken = 1'b0;
    chk("redir_addr", 32'(imem_req ? imem_addr : 8'hEE), 32'hFE);
    n = 0;
    while (!(instr_valid && instr_pc == 8'hFF) && n < 20) begin step(); n++; end
    chk("wait_vff", 32'(n < 20), 32'h1);
    chk("wrap_pc", 32'(pc_out), 32'h00);
    n = 0;
    while (!(instr_valid && instr_pc == 8'h00) && n < 20) begin step(); n++; end
    chk("wait_v00", 32'(n < 20), 32'h1);
    mem_en = 1'b0;

    // timeout on 01
    step();
    n = 0;
    while (!fetch_err && n < 40) begin
      if (imem_req) n++;
      step();
    end
    chk("to_req_cycles", 32'(n), 32'd15);
    chk("to_err", 32'(fetch_err), 32'h1);
    chk("to_pc", 32'(pc_out), 32'h01);
    for (int i = 0; i < 5; i++) begin
      chk("to_no_req", 32'(imem_req), 32'h0);
      chk("to_sticky", 32'(fetch_err), 32'h1);
      step();
    end

    // asynchronous reset in the middle of a cycle
    rst = 1'b1;
    #1;
    chk("arst_req", 32'(imem_req), 32'h0);
    chk("arst_err", 32'(fetch_err), 32'h0);
    chk("arst_pc", 32'(pc_out), 32'h00);
    chk("arst_valid", 32'(instr_valid), 32'h0);
    chk("arst_out", 32'(instr_out), 32'h0);
    chk("arst_ipc", 32'(instr_pc), 32'h0);
    stall = 1'b1;
    mem_en = 1'b1;
    push_exp(8'h3C, 8'h00);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_idle", 32'(imem_req), 32'h0);
    end
    stall = 1'b0;
    n = 0;
    while (!imem_req && n < 5) begin step(); n++; end
    chk("post_rst_addr", 32'(imem_req ? imem_addr : 8'hEE), 32'h00);
    n = 0;
    while (!(instr_valid && instr_pc == 8'h00) && n < 10) begin step(); n++; end
    chk("wait_post_rst_v00", 32'(n < 10), 32'h1);
    step();
    step();
    chk("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
